// File: rtl/life_matrix_scan.sv
// life_matrix_scan: row-multiplexed driver for the 8x8 Game-of-Life LED grid.
// Incoming generations land in a shadow buffer and are only promoted to the
// active (displayed) buffer at a frame boundary, so a frame is never torn.
// Optional build macro: LIFE_SCAN_BLANK_EN inserts a 2-cycle dark gap after
// every row to suppress ghosting between rows.
module life_matrix_scan #(
    parameter int DWELL = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] grid,
    input  logic        grid_valid,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic [15:0] gen_count
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
`ifdef LIFE_SCAN_BLANK_EN
    localparam logic [15:0] BLANK_LAST = 16'd1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1
`ifdef LIFE_SCAN_BLANK_EN
        ,
        BLANK = 2'd2
`endif
    } state_t;

    state_t      state, state_next;
    logic [2:0]  row, row_next;
    logic [15:0] dwell, dwell_next;
    logic [63:0] shadow, shadow_next;
    logic [63:0] active, active_next;
    logic        pending, pending_next;
    logic        swap;
    logic [15:0] gen_count_next;
    logic [7:0]  row_sel_next;
    logic [7:0]  col_data_next;
    logic        frame_done_next;

    // Scan sequencing: decide the next state, row and dwell position, and
    // whether this edge promotes the shadow buffer into the active buffer.
    always_comb begin
        state_next = state;
        row_next   = row;
        dwell_next = dwell;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    swap       = 1'b1;
                    state_next = SCAN;
                    row_next   = 3'd0;
                    dwell_next = 16'd0;
                end
            end
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = 16'd0;
                    row_next   = row + 3'd1;
                    swap       = pending && (row == 3'd7);
`ifdef LIFE_SCAN_BLANK_EN
                    state_next = BLANK;
`endif
                end else begin
                    dwell_next = dwell + 16'd1;
                end
            end
`ifdef LIFE_SCAN_BLANK_EN
            BLANK: begin
                if (dwell == BLANK_LAST) begin
                    dwell_next = 16'd0;
                    state_next = SCAN;
                end else begin
                    dwell_next = dwell + 16'd1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Buffer bookkeeping: a swap reads the shadow as it was before this edge,
    // so a grid arriving on the swap edge stays pending for the next frame.
    always_comb begin
        shadow_next    = grid_valid ? grid : shadow;
        pending_next   = grid_valid | (pending & ~swap);
        active_next    = swap ? shadow : active;
        gen_count_next = gen_count;
        if (grid_valid && (gen_count != 16'hFFFF)) begin
            gen_count_next = gen_count + 16'd1;
        end
    end

    // Output decode from the upcoming state so every output is a register.
    always_comb begin
        row_sel_next    = 8'h00;
        col_data_next   = 8'h00;
        frame_done_next = 1'b0;
        if (state_next == SCAN) begin
            row_sel_next  = 8'd1 << row_next;
            col_data_next = active_next[{row_next, 3'b000} +: 8];
        end
`ifdef LIFE_SCAN_BLANK_EN
        frame_done_next = (state_next == BLANK) && (row_next == 3'd0) &&
                          (dwell_next == BLANK_LAST);
`else
        frame_done_next = (state_next == SCAN) && (row_next == 3'd7) &&
                          (dwell_next == DWELL_LAST);
`endif
    end

    // State, counters and buffers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            row     <= 3'd0;
            dwell   <= 16'd0;
            shadow  <= 64'd0;
            active  <= 64'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            row     <= row_next;
            dwell   <= dwell_next;
            shadow  <= shadow_next;
            active  <= active_next;
            pending <= pending_next;
        end
    end

    // Registered outputs; reset blanks the matrix without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_sel    <= 8'h00;
            col_data   <= 8'h00;
            frame_done <= 1'b0;
            gen_count  <= 16'd0;
        end else begin
            row_sel    <= row_sel_next;
            col_data   <= col_data_next;
            frame_done <= frame_done_next;
            gen_count  <= gen_count_next;
        end
    end

endmodule

// File: tb/tb_life_matrix_scan.sv
// tb_life_matrix_scan: scoreboard bench for life_matrix_scan with DWELL=4.
// A frame-position reference model pushes the expected outputs after every
// rising edge; each scenario task pops and compares on the falling edge.
// Honours LIFE_SCAN_BLANK_EN the same way the design does.
module tb_life_matrix_scan;

    localparam int DWELL = 4;
`ifdef LIFE_SCAN_BLANK_EN
    localparam int BLANKC = 2;
`else
    localparam int BLANKC = 0;
`endif
    localparam int RP       = DWELL + BLANKC;
    localparam int P        = 8 * RP;
    localparam int SWAP_POS = (BLANKC == 0) ? 0 : 7 * RP + DWELL;

    typedef struct packed {
        logic [7:0]  rs;
        logic [7:0]  cd;
        logic        fd;
        logic [15:0] gc;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] grid;
    logic        grid_valid;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic [15:0] gen_count;
    obs_t        obs;

    obs_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    bit          m_run     = 1'b0;
    int          m_pos     = 0;
    logic [63:0] m_shadow  = '0;
    logic [63:0] m_active  = '0;
    bit          m_pending = 1'b0;
    logic [15:0] m_gen     = '0;

    life_matrix_scan #(.DWELL(DWELL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .grid       (grid),
        .grid_valid (grid_valid),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done),
        .gen_count  (gen_count)
    );

    assign obs = {row_sel, col_data, frame_done, gen_count};

    always #5 clk = ~clk;

    // Reference model: tracks the position inside the frame and which grid
    // is on display, then predicts the outputs visible after this edge.
    initial begin : model
        obs_t e;
        int   r;
        int   off;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_run = 0; m_pos = 0; m_shadow = '0; m_active = '0;
                m_pending = 0; m_gen = '0;
            end else begin
                if (m_run) begin
                    m_pos = (m_pos + 1) % P;
                    if (m_pos == SWAP_POS && m_pending) begin
                        m_active = m_shadow; m_pending = 0;
                    end
                end else if (m_pending) begin
                    m_run = 1; m_pos = 0; m_active = m_shadow; m_pending = 0;
                end
                if (grid_valid) begin
                    m_shadow = grid; m_pending = 1;
                    if (m_gen != 16'hFFFF) m_gen = m_gen + 16'd1;
                end
            end
            e = '0;
            if (m_run) begin
                r   = m_pos / RP;
                off = m_pos % RP;
                if (off < DWELL) begin
                    e.rs = 8'(1 << r);
                    e.cd = m_active[8*r +: 8];
                end
                e.fd = (m_pos == P - 1);
            end
            e.gc = m_gen;
            sb.push_back(e);
        end
    end

    task automatic test_reset();
        obs_t e;
        for (int i = 0; i < 103; i++) begin
            @(negedge clk);
            e = sb.pop_front(); compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL reset_sb cyc %0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, obs.rs, obs.cd, obs.fd, obs.gc, e.rs, e.cd, e.fd, e.gc);
            end
            compared++;
            if (obs !== 33'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_idle cyc %0d: got %h want 0", i, obs);
            end
            if (i == 2) reset_n = 1'b1;
        end
    endtask

    task automatic test_single_row();
        obs_t e;
        int   fd_count = 0;
        for (int i = 0; i < 2*P + 4; i++) begin
            @(negedge clk);
            e = sb.pop_front(); compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL single_sb cyc %0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, obs.rs, obs.cd, obs.fd, obs.gc, e.rs, e.cd, e.fd, e.gc);
            end
            if (i >= 2 && i < 2 + DWELL) begin
                compared++;
                if (row_sel !== 8'h01 || col_data !== 8'hFF) begin
                    mismatched++;
                    $display("[TB] FAIL single_row0 cyc %0d: got %h/%h want 01/ff", i, row_sel, col_data);
                end
            end
            if (i == 2 + RP) begin
                compared++;
                if (row_sel !== 8'h02 || col_data !== 8'h00) begin
                    mismatched++;
                    $display("[TB] FAIL single_row1 cyc %0d: got %h/%h want 02/00", i, row_sel, col_data);
                end
            end
            if (i >= 2 && i < 2 + 2*P && frame_done === 1'b1) fd_count++;
            grid_valid = (i == 0);
            if (i == 0) grid = 64'h0000_0000_0000_00FF;
        end
        compared++;
        if (fd_count != 2) begin
            mismatched++;
            $display("[TB] FAIL single_fd_count: got %0d want 2", fd_count);
        end
        compared++;
        if (gen_count !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL single_gen: got %0d want 1", gen_count);
        end
    endtask

    task automatic test_update_mid_frame();
        obs_t        e;
        logic [63:0] ga = 64'h8000_0000_0000_0001;
        logic [63:0] gb = 64'hFFFF_FFFF_FFFF_FFFF;
        bit          sent_b = 0, check_next = 0, done = 0;
        for (int i = 0; i < 5*P; i++) begin
            @(negedge clk);
            e = sb.pop_front(); compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL mid_sb cyc %0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, obs.rs, obs.cd, obs.fd, obs.gc, e.rs, e.cd, e.fd, e.gc);
            end
            if (check_next) begin
                compared++; check_next = 0; done = 1;
                if (row_sel !== 8'h01 || col_data !== 8'hFF) begin
                    mismatched++;
                    $display("[TB] FAIL mid_new_row0: got %h/%h want 01/ff", row_sel, col_data);
                end
            end
            if (sent_b && !done && frame_done === 1'b1) check_next = 1;
            if (m_active == ga && row_sel === 8'h80) begin
                compared++;
                if (col_data !== 8'h80) begin
                    mismatched++;
                    $display("[TB] FAIL mid_row7_old cyc %0d: got %h want 80", i, col_data);
                end
            end
            grid_valid = 1'b0;
            if (i == 0) begin
                grid_valid = 1'b1; grid = ga;
            end else if (!sent_b && m_run && m_active == ga && m_pos == 3*RP) begin
                grid_valid = 1'b1; grid = gb; sent_b = 1;
            end
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("[TB] FAIL mid_swap_seen: got 0 want 1");
        end
    endtask

    task automatic test_multi_strobe();
        obs_t e;
        int   base = -1;
        for (int i = 0; i < 3*P + 8; i++) begin
            @(negedge clk);
            e = sb.pop_front(); compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL multi_sb cyc %0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, obs.rs, obs.cd, obs.fd, obs.gc, e.rs, e.cd, e.fd, e.gc);
            end
            if (base >= 0 && i == base + P) begin
                compared++;
                if (row_sel !== 8'h01 || col_data !== 8'hFF) begin
                    mismatched++;
                    $display("[TB] FAIL multi_last_row0: got %h/%h want 01/ff", row_sel, col_data);
                end
                compared++;
                if (gen_count !== 16'd6) begin
                    mismatched++;
                    $display("[TB] FAIL multi_gen: got %0d want 6", gen_count);
                end
            end
            if (base >= 0 && i == base + P + RP) begin
                compared++;
                if (row_sel !== 8'h02 || col_data !== 8'h00) begin
                    mismatched++;
                    $display("[TB] FAIL multi_last_row1: got %h/%h want 02/00", row_sel, col_data);
                end
            end
            grid_valid = 1'b0;
            if (base < 0 && m_run && m_pos == 0) base = i;
            if (base >= 0) begin
                case (i - base)
                    2:  begin grid_valid = 1'b1; grid = 64'h0000_0000_0000_0011; end
                    10: begin grid_valid = 1'b1; grid = 64'h0000_0000_0000_0022; end
                    20: begin grid_valid = 1'b1; grid = 64'h00FF_00FF_00FF_00FF; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_coincident();
        obs_t e;
        int   base = -1;
        for (int i = 0; i < 3*P + 8; i++) begin
            @(negedge clk);
            e = sb.pop_front(); compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL coinc_sb cyc %0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, obs.rs, obs.cd, obs.fd, obs.gc, e.rs, e.cd, e.fd, e.gc);
            end
            if (base >= 0 && i == base + P - 1) begin
                compared++;
                if (frame_done !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL coinc_fd: got %b want 1", frame_done);
                end
            end
            if (base >= 0 && i == base + P) begin
                compared++;
                if (row_sel !== 8'h01 || col_data !== 8'hAA) begin
                    mismatched++;
                    $display("[TB] FAIL coinc_first: got %h/%h want 01/aa", row_sel, col_data);
                end
            end
            if (base >= 0 && i == base + 2*P) begin
                compared++;
                if (row_sel !== 8'h01 || col_data !== 8'h33) begin
                    mismatched++;
                    $display("[TB] FAIL coinc_second: got %h/%h want 01/33", row_sel, col_data);
                end
                compared++;
                if (gen_count !== 16'd8) begin
                    mismatched++;
                    $display("[TB] FAIL coinc_gen: got %0d want 8", gen_count);
                end
            end
            grid_valid = 1'b0;
            if (base < 0 && m_run && m_pos == 0) base = i;
            if (base >= 0 && i == base + 5) begin
                grid_valid = 1'b1; grid = 64'h0000_0000_0000_00AA;
            end
            if (base >= 0 && i == base + P - 1) begin
                grid_valid = 1'b1; grid = 64'h0000_0000_0000_0033;
            end
        end
    endtask

    task automatic test_frame_period();
        obs_t e;
        int   first = -1, second = -1, zeros = 0, run = 0;
        for (int i = 0; i < 3*P + 4; i++) begin
            @(negedge clk);
            e = sb.pop_front(); compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL period_sb cyc %0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, obs.rs, obs.cd, obs.fd, obs.gc, e.rs, e.cd, e.fd, e.gc);
            end
            if (first >= 0 && second < 0) begin
                if (row_sel === 8'h00) begin
                    zeros++; run++;
                    compared++;
                    if (col_data !== 8'h00) begin
                        mismatched++;
                        $display("[TB] FAIL blank_cols cyc %0d: got %h want 00", i, col_data);
                    end
                end else begin
                    if (run > 0) begin
                        compared++;
                        if (run != BLANKC) begin
                            mismatched++;
                            $display("[TB] FAIL blank_run: got %0d want %0d", run, BLANKC);
                        end
                    end
                    run = 0;
                end
            end
            if (frame_done === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        compared++;
        if (second < 0 || (second - first) != P) begin
            mismatched++;
            $display("[TB] FAIL frame_period: got %0d want %0d", second - first, P);
        end
        compared++;
        if (zeros != 8*BLANKC) begin
            mismatched++;
            $display("[TB] FAIL blank_total: got %0d want %0d", zeros, 8*BLANKC);
        end
    endtask

    task automatic test_async_reset();
        obs_t e;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            e = sb.pop_front(); compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL areset_sb cyc %0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, obs.rs, obs.cd, obs.fd, obs.gc, e.rs, e.cd, e.fd, e.gc);
            end
            if (i >= 14 && i < 54) begin
                compared++;
                if (row_sel !== 8'h00 || col_data !== 8'h00 || frame_done !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL areset_idle cyc %0d: got %h/%h/%b want 00/00/0", i, row_sel, col_data, frame_done);
                end
            end
            if (i == 56) begin
                compared++;
                if (row_sel !== 8'h01 || col_data !== 8'h67 || gen_count !== 16'd1) begin
                    mismatched++;
                    $display("[TB] FAIL areset_restart: got %h/%h/%0d want 01/67/1", row_sel, col_data, gen_count);
                end
            end
            grid_valid = 1'b0;
            if (i == 10) begin
                #2 reset_n = 1'b0;
                #1;
                compared++;
                if (obs !== 33'd0) begin
                    mismatched++;
                    $display("[TB] FAIL areset_immediate: got %h want 0", obs);
                end
            end
            if (i == 13) reset_n = 1'b1;
            if (i == 54) begin
                grid_valid = 1'b1; grid = 64'hDEAD_BEEF_0123_4567;
            end
        end
    endtask

    task automatic test_saturation();
        obs_t     e;
        localparam int N = 65540;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            e = sb.pop_front(); compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL sat_sb cyc %0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, obs.rs, obs.cd, obs.fd, obs.gc, e.rs, e.cd, e.fd, e.gc);
            end
            if (i >= N - 2) begin
                compared++;
                if (gen_count !== 16'hFFFF) begin
                    mismatched++;
                    $display("[TB] FAIL sat_hold cyc %0d: got %h want ffff", i, gen_count);
                end
            end
            grid_valid = 1'b1;
            grid       = {$urandom, $urandom};
        end
        grid_valid = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        grid       = '0;
        grid_valid = 1'b0;
        test_reset();
        test_single_row();
        test_update_mid_frame();
        test_multi_strobe();
        test_coincident();
        test_frame_period();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
